// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// Owner-state encoding, port indices and the burst counter width/helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_DMA    = 1'b1;
  localparam int   BURST_CNT_W = 4;

  // Increment that sticks at all-ones so a long single-port run never wraps.
  function automatic logic [BURST_CNT_W-1:0] burst_inc(input logic [BURST_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
// A lone requester always wins. On a tie, a valid holding owner keeps the
// grant; otherwise the port that was not served last wins.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       hold_owner,
  input  logic       hold_valid,
  output logic [1:0] win
);

  // Pick at most one winner from the request pair.
  always_comb begin
    win = 2'b00;
    if (req[PORT_CPU] && !req[PORT_DMA]) begin
      win[PORT_CPU] = 1'b1;
    end else if (req[PORT_DMA] && !req[PORT_CPU]) begin
      win[PORT_DMA] = 1'b1;
    end else if (req[PORT_CPU] && req[PORT_DMA]) begin
      if (hold_valid) win[hold_owner] = 1'b1;
      else            win[~last]      = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between the CPU load/store port
// (port 0) and the loader/DMA port (port 1). One access per granted cycle,
// read data returned one cycle later with a per-port valid strobe.
// Build option: define DMEM_ARB_BURST_EN to let the current owner hold the
// memory for up to MAX_BURST consecutive grants while the other port waits;
// without it, contending ports strictly alternate.
//
// owner state | meaning
// ------------+---------------------------------------------------
// IDLE        | no grant last cycle (reset, or nobody requested)
// OWN0        | CPU port was granted last cycle
// OWN1        | DMA port was granted last cycle
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              stall0,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_max_burst_range
    $error("dmem_arbiter: MAX_BURST must be within 1..15");
  end

  owner_e     owner, owner_nxt;
  logic       last, last_nxt;
  logic [1:0] win, gnt;
  logic       hold_owner, hold_valid;
  logic       rd_take;

`ifdef DMEM_ARB_BURST_EN
  logic [BURST_CNT_W-1:0] burst_cnt, burst_nxt;
  assign hold_valid = (owner != IDLE) && (burst_cnt < BURST_CNT_W'(MAX_BURST));
`else
  assign hold_valid = 1'b0;
`endif

  assign hold_owner = (owner == OWN1);

  rr_pick2 u_pick (
    .req        ({req1, req0}),
    .last       (last),
    .hold_owner (hold_owner),
    .hold_valid (hold_valid),
    .win        (win)
  );

  // Nothing is granted while reset is held, so no access leaks to dmem.
  assign gnt    = reset ? 2'b00 : win;
  assign gnt0   = gnt[PORT_CPU];
  assign gnt1   = gnt[PORT_DMA];
  assign stall0 = req0 & ~gnt0;
  assign rd_take = (gnt0 & ~we0) | (gnt1 & ~we1);

  // Steer the winning port onto the memory; idle bus is driven to zero.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Next owner / last-served / burst length from this cycle's grant.
  always_comb begin
    owner_nxt = IDLE;
    last_nxt  = last;
`ifdef DMEM_ARB_BURST_EN
    burst_nxt = '0;
`endif
    if (gnt0) begin
      owner_nxt = OWN0;
      last_nxt  = PORT_CPU;
`ifdef DMEM_ARB_BURST_EN
      burst_nxt = (owner == OWN0) ? burst_inc(burst_cnt) : BURST_CNT_W'(1);
`endif
    end else if (gnt1) begin
      owner_nxt = OWN1;
      last_nxt  = PORT_DMA;
`ifdef DMEM_ARB_BURST_EN
      burst_nxt = (owner == OWN1) ? burst_inc(burst_cnt) : BURST_CNT_W'(1);
`endif
    end
  end

  // Arbitration state; last resets to the DMA port so the CPU wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= IDLE;
      last  <= PORT_DMA;
`ifdef DMEM_ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      owner <= owner_nxt;
      last  <= last_nxt;
`ifdef DMEM_ARB_BURST_EN
      burst_cnt <= burst_nxt;
`endif
    end
  end

  // Read return: capture dmem data one cycle after a granted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (rd_take) rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: bench for dmem_arbiter with a behavioural dmem, a
// cycle-level reference model and directed stimulus. Honours DMEM_ARB_BURST_EN.
module tb_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef DMEM_ARB_BURST_EN
  localparam int LIMIT = 4;
  localparam bit BURST = 1'b1;
`else
  localparam int LIMIT = 1;
  localparam bit BURST = 1'b0;
`endif

  logic              clk, reset;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, stall0, mem_we;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .stall0(stall0), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem: 64 x 32, combinational read, write on posedge
  logic [31:0] ram [64];
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_mem [64];
  int          m_own, m_last, m_streak;
  logic        m_rv0, m_rv1;
  logic [31:0] m_rdata;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]   = 32'hDEAD0000 + i;
      m_mem[i] = 32'hDEAD0000 + i;
    end
    m_own = -1; m_last = 1; m_streak = 0;
    m_rv0 = 1'b0; m_rv1 = 1'b0; m_rdata = '0;
  end

  // Compare process: every cycle, DUT outputs vs model
  always @(negedge clk) begin
    int          w;
    logic        e_g0, e_g1, e_we;
    logic [31:0] e_a, e_d;
    if (reset) begin
      m_own = -1; m_last = 1; m_streak = 0;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rdata = '0;
    end
    chk("rvalid0", rvalid0, m_rv0);
    chk("rvalid1", rvalid1, m_rv1);
    chk("rdata", rdata, m_rdata);

    w = -1;
    if (!reset) begin
      if (req0 && !req1)      w = 0;
      else if (req1 && !req0) w = 1;
      else if (req0 && req1)  w = (m_own >= 0 && m_streak < LIMIT) ? m_own : 1 - m_last;
    end
    e_g0 = (w == 0); e_g1 = (w == 1);
    e_we = 1'b0; e_a = '0; e_d = '0;
    if (w == 0)      begin e_we = we0; e_a = addr0; e_d = wdata0; end
    else if (w == 1) begin e_we = we1; e_a = addr1; e_d = wdata1; end
    chk("gnt0", gnt0, e_g0);
    chk("gnt1", gnt1, e_g1);
    chk("stall0", stall0, req0 && !e_g0);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_a);
    chk("mem_wdata", mem_wdata, e_d);

    m_rv0 = 1'b0; m_rv1 = 1'b0;
    if (w >= 0) begin
      m_streak = (w == m_own) ? ((m_streak < 15) ? m_streak + 1 : 15) : 1;
      m_own  = w;
      m_last = w;
      if (e_we) m_mem[e_a[7:2]] = e_d;
      else begin
        m_rdata = m_mem[e_a[7:2]];
        if (w == 0) m_rv0 = 1'b1; else m_rv1 = 1'b1;
      end
    end else begin
      m_own = -1;
      m_streak = 0;
    end
  end

  // Directed stimulus with hand-computed literal expectations
  logic [7:0] pat;
  initial begin
    reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pat = BURST ? 8'b0000_1111 : 8'b0101_0101;
    repeat (3) @(posedge clk);

    // first read after reset release
    #1; reset = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
    @(negedge clk); chk("t1_gnt0", gnt0, 1); chk("t1_gnt1", gnt1, 0);
    @(posedge clk); #1; req0 = 1'b0;
    @(negedge clk); chk("t1_rvalid0", rvalid0, 1); chk("t1_rdata", rdata, 32'hDEAD0002);

    // port 1 write, then port 0 reads it back
    @(posedge clk); #1; req1 = 1'b1; we1 = 1'b1; addr1 = 32'h14; wdata1 = 32'h12345678;
    @(negedge clk); chk("wr_gnt1", gnt1, 1); chk("wr_mem_we", mem_we, 1);
    @(posedge clk); #1; req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; addr0 = 32'h14;
    @(negedge clk); chk("rd_gnt0", gnt0, 1); chk("wr_no_rvalid1", rvalid1, 0);
    @(posedge clk); #1; req0 = 1'b0;
    @(negedge clk); chk("rd_rvalid0", rvalid0, 1); chk("rd_rdata", rdata, 32'h12345678);
    chk("rd_no_rvalid1", rvalid1, 0);

    // port 1 read so port 1 is last served, then an idle cycle
    @(posedge clk); #1; req1 = 1'b1; addr1 = 32'h0;
    @(posedge clk); #1; req1 = 1'b0;

    // contention for 8 cycles
    @(posedge clk); #1; req0 = 1'b1; req1 = 1'b1; addr0 = 32'h4; addr1 = 32'h8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("cont_gnt0", gnt0, pat[i]);
      chk("cont_stall0", stall0, !pat[i]);
      if (i < 7) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1; req0 = 1'b0; req1 = 1'b0;

    // long port 1 run, burst count must saturate, not wrap
    @(posedge clk); #1; req1 = 1'b1; addr1 = 32'h20;
    repeat (17) @(posedge clk);
    #1; req0 = 1'b1;
    @(negedge clk); chk("sat_gnt0", gnt0, 1);
    @(posedge clk); #1; req0 = 1'b0; req1 = 1'b0;

    // reset asserted mid-burst while a port 1 read is granted
    @(posedge clk); #1; req1 = 1'b1; addr1 = 32'h10;
    @(posedge clk); #1;
    #2; chk("rst_pre_gnt1", gnt1, 1);
    reset = 1'b1; req0 = 1'b1;
    #1; chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_we", mem_we, 0); chk("rst_stall0", stall0, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("rst_rvalid1", rvalid1, 0);
    @(posedge clk); #1; reset = 1'b0; addr0 = 32'h0;
    @(negedge clk); chk("post_rst_gnt0", gnt0, 1); chk("post_rst_gnt1", gnt1, 0);
    @(posedge clk); #1; req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory (`dmem`, 64 x 32-bit, combinational read, write on posedge) between the `data_path` load/store port (port 0, CPU) and a loader/DMA port (port 1). It sits between both requesters and `dmem` and performs one memory access per granted cycle. It returns read data one cycle later with a valid strobe, and gives the CPU a stall signal while it waits. Fairness is round-robin with optional burst hold.

## Interface
- `ADDR_W`, 32, address width on both ports and the memory side
- `DATA_W`, 32, data width
- `MAX_BURST`, 4, maximum consecutive grants to one port while the other is requesting (burst mode only); legal range 1..15
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0`, `req1`  in  1  access request, ports 0/1
- `we0`, `we1`  in  1  1 = write, 0 = read; held with `req` until granted
- `addr0`, `addr1`  in  ADDR_W  byte address; passed through unmodified
- `wdata0`, `wdata1`  in  DATA_W  write data
- `gnt0`, `gnt1`  out  1  access performed this cycle (combinational, one-hot or zero)
- `rvalid0`, `rvalid1`  out  1  registered; `rdata` is valid for the read granted in the previous cycle
- `rdata`  out  DATA_W  registered read data, shared by both ports
- `stall0`  out  1  `req0 & ~gnt0`; drives the CPU pipeline stall
- `mem_we`  out  1  to `dmem.we`
- `mem_addr`  out  ADDR_W  to `dmem.addr`
- `mem_wdata`  out  DATA_W  to `dmem.write_data`
- `mem_rdata`  in  DATA_W  from `dmem.read_data`

## Operation
- State: `owner` (IDLE, OWN0, OWN1), `last` (last port served), 4-bit `burst_cnt`.
- Each cycle the winner is chosen from `req0`/`req1`, `owner`, `last`, and `burst_cnt`:
  - Only one request: that port wins.
  - Both request and the current owner is still requesting with `burst_cnt < MAX_BURST`: the owner wins.
  - Otherwise: the port != `last` wins.
- Winner `i`: `gnt_i`=1. Mux `we_i`/`addr_i`/`wdata_i` onto the `mem_*` outputs; `mem_we` = `we_i`.
- No winner: `mem_we`=0, `mem_addr`/`mem_wdata` = 0.
- Posedge after a grant to `i`:
  - `owner`<=OWN_i, `last`<=i.
  - `burst_cnt`<=`burst_cnt`+1 if same owner, else 1 (saturates at 15).
  - On a read, `rdata`<=`mem_rdata` and `rvalid_i`<=1.
- Posedge with no grant: `owner`<=IDLE, `burst_cnt`<=0, `last` unchanged, `rvalid*`<=0.
- Writes produce no `rvalid`.
- Requester rule: keep `req`/`we`/`addr`/`wdata` stable until the cycle `gnt` is high. Deassert or issue a new request on the next cycle.

## Timing
- Grant latency: 0 cycles when uncontended. A contended port waits at most `MAX_BURST` cycles (burst) or 1 cycle (no burst).
- Write lands in `dmem` at the posedge ending the grant cycle.
- Read data: `rvalid`/`rdata` asserted exactly 1 cycle after `gnt`, for 1 cycle. `rdata` holds its value otherwise.
- Back-to-back grants to the same port give one access per cycle, so throughput is 1 access/cycle.
- Reset values:
  - `owner`=IDLE, `last`=1 (port 0 wins the first tie), `burst_cnt`=0.
  - `rvalid*`=0, `rdata`=0.
- While `reset` is high: `gnt*`=0, `mem_we`=0, `stall0`=`req0`.
- Reset asserted mid-burst aborts the burst. A read granted in the cycle of reset assertion produces no `rvalid`.
- Simultaneous first requests after reset or idle: port 0 is granted.

## Configuration
- `DMEM_ARB_BURST_EN` defined: burst hold up to `MAX_BURST` as above.
- Not defined:
  - Strict alternation whenever both request (effective `MAX_BURST`=1).
  - `burst_cnt` is not implemented.
  - `MAX_BURST` is ignored.

## Structure
- Package `dmem_arb_pkg`:
  - owner state enum (IDLE, OWN0, OWN1)
  - port index constants `PORT_CPU`=0, `PORT_DMA`=1
  - `BURST_CNT_W`=4
- Sub-module `rr_pick2`: combinational 2-way round-robin picker.
  - Inputs: `req[1:0]`, `last`, `hold_owner`, `hold_valid`.
  - Output: one-hot `win[1:0]`.
- `dmem_arbiter` contains the registers, the muxes, and the read-return path. Bench reuses the existing `dmem` model.

## Test plan
- Reset release with `req0`=1, read of `addr0`=0x8 (RAM word 2 = 0xDEAD0002) -> `gnt0` same cycle, next cycle `rvalid0`=1, `rdata`=0xDEAD0002.
- `req0` and `req1` both held for 8 cycles, burst on, `MAX_BURST`=4 -> grants 0,0,0,0,1,1,1,1; `stall0`=1 on cycles 5-8.
- Same stimulus, macro undefined -> grants alternate 0,1,0,1,...
- Port 1 writes 0x12345678 to 0x14, then port 0 reads 0x14 on the next cycle -> `rvalid0` with `rdata`=0x12345678, no `rvalid1`.
- `reset` asserted mid-burst with a port 1 read granted in that cycle -> `gnt*`/`mem_we` drop immediately, `rvalid1` stays 0. After release, simultaneous requests grant port 0 first.
